// File: rtl/csr_seg_gen.sv
// CSR segment generator: turns one tile's row end pointers into per-batch
// N-lane segment descriptors for the reduction unit. Optional macro: SEG_OUT_REG_EN.
module csr_seg_gen #(
  parameter int unsigned N = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           lhs_start,
  input  logic [N*2*$clog2(N)-1:0]       lhs_ptr,
  output logic                           lhs_ready,
  output logic                           seg_valid,
  input  logic                           seg_ready,
  output logic [N-1:0]                   seg_split,
  output logic [N*$clog2(N)-1:0]         seg_out_idx,
  output logic [N-1:0]                   seg_lane_vld,
  output logic                           seg_carry,
  output logic                           seg_last,
  output logic                           done
);

  localparam int unsigned LGN = $clog2(N);
  localparam int unsigned DB  = 2 * LGN;
  localparam int unsigned PW  = DB + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DB-1:0]    ptr_q [N];
  logic [LGN-1:0]   k_q;
  logic             gen_done_q;

  logic             g_valid, g_ready;
  logic [N-1:0]     g_split, g_vld;
  logic [N*LGN-1:0] g_idx;
  logic             g_carry, g_last;
  logic [PW-1:0]    total, base, p;
  logic [LGN-1:0]   row;

  assign lhs_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign g_valid   = (state_q == RUN) && !gen_done_q;

  // Descriptor for batch k; all-zero whenever no batch is being generated
  always_comb begin
    g_split = '0;
    g_vld   = '0;
    g_idx   = '0;
    g_carry = 1'b0;
    g_last  = 1'b0;
    p       = '0;
    row     = '0;
    total   = PW'(ptr_q[N-1]);
    base    = PW'(k_q) * PW'(N);
    if (g_valid) begin
      for (int j = 0; j < N; j++) begin
        p   = base + PW'(j);
        row = '0;
        if (p < total) begin
          for (int i = N - 1; i >= 0; i--) begin
            if (PW'(ptr_q[i]) > p) row = LGN'(i);
          end
          g_vld[j]              = 1'b1;
          g_idx[j*LGN +: LGN]   = row;
          g_split[j]            = (p + PW'(1) == PW'(ptr_q[row])) || (j == N - 1) ||
                                  (p + PW'(1) == total);
        end
      end
      // Lane 0 continues a row unless some row ends exactly at the batch boundary
      g_carry = (k_q != '0);
      for (int i = 0; i < N; i++) begin
        if (PW'(ptr_q[i]) == base) g_carry = 1'b0;
      end
      g_last = (base + PW'(N)) >= total;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (lhs_start) state_d = (lhs_ptr[(N-1)*DB +: DB] != '0) ? RUN : DONE;
      RUN:  if (seg_valid && seg_ready && seg_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pointer capture and batch counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) ptr_q[i] <= '0;
      k_q        <= '0;
      gen_done_q <= 1'b0;
    end else if (state_q == IDLE) begin
      k_q        <= '0;
      gen_done_q <= 1'b0;
      if (lhs_start) begin
        for (int i = 0; i < N; i++) ptr_q[i] <= lhs_ptr[i*DB +: DB];
      end
    end else if (g_valid && g_ready) begin
      k_q <= k_q + LGN'(1);
      if (g_last) gen_done_q <= 1'b1;
    end
  end

`ifdef SEG_OUT_REG_EN
  assign g_ready = !seg_valid || seg_ready;

  // One-entry output slice; empties to all-zero once generation stops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_valid    <= 1'b0;
      seg_split    <= '0;
      seg_out_idx  <= '0;
      seg_lane_vld <= '0;
      seg_carry    <= 1'b0;
      seg_last     <= 1'b0;
    end else if (g_ready) begin
      seg_valid    <= g_valid;
      seg_split    <= g_split;
      seg_out_idx  <= g_idx;
      seg_lane_vld <= g_vld;
      seg_carry    <= g_carry;
      seg_last     <= g_last;
    end
  end
`else
  assign g_ready      = seg_ready;
  assign seg_valid    = g_valid;
  assign seg_split    = g_split;
  assign seg_out_idx  = g_idx;
  assign seg_lane_vld = g_vld;
  assign seg_carry    = g_carry;
  assign seg_last     = g_last;
`endif

endmodule

// File: doc/csr_seg_gen.md
CSR_SEG_GEN -- requirements
Module: csr_seg_gen

Role: upstream of the reduction unit. Converts one tile's CSR row pointers into per-batch segment control (split, out_idx, lane valid) for N-wide reduction.

Interface
REQ-001 Parameter: N, from macro N, default 16; W=8 unused; lgN=clog2(N); dbLgN=2*lgN.
REQ-002 clock  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 = reset.
REQ-004 lhs_start  input  1  pulse; accept tile pointers.
REQ-005 lhs_ptr  input  N x dbLgN  exclusive end pointer of row i (cumulative nnz); nondecreasing; lhs_ptr[N-1]=total nnz.
REQ-006 lhs_ready  output  1  high only in IDLE.
REQ-007 seg_valid  output  1  batch descriptor valid.
REQ-008 seg_ready  input  1  consumer accepts batch.
REQ-009 seg_split  output  N x 1  lane ends a segment.
REQ-010 seg_out_idx  output  N x lgN  row index of lane's element.
REQ-011 seg_lane_vld  output  N x 1  lane holds a real nonzero.
REQ-012 seg_carry  output  1  lane 0 continues a row from the previous batch.
REQ-013 seg_last  output  1  final batch of tile.
REQ-014 done  output  1  one-cycle pulse at tile end.

Function
REQ-015 States IDLE, RUN, DONE; IDLE->RUN on lhs_start with total>0; IDLE->DONE on lhs_start with total=0; RUN->DONE on handshake of seg_last batch; DONE->IDLE after one cycle.
REQ-016 lhs_ptr is captured into internal registers on the accepted lhs_start; later input changes have no effect on the tile.
REQ-017 lhs_start outside IDLE is ignored.
REQ-018 Batch counter k starts at 0; lane j position p=k*N+j; increments only when seg_valid && seg_ready.
REQ-019 seg_out_idx[j] = smallest i with lhs_ptr[i] > p; 0 when lane invalid.
REQ-020 seg_lane_vld[j] = (p < total).
REQ-021 seg_split[j] = lane valid && (p+1 == lhs_ptr[row] || j == N-1 || p+1 == total).
REQ-022 seg_carry = k>0 && position k*N-1 and k*N lie in the same row.
REQ-023 seg_last = ((k+1)*N >= total); batches = ceil(total/N).
REQ-024 seg_valid high throughout RUN; all seg_* stable while seg_valid && !seg_ready.
REQ-025 Empty rows (lhs_ptr[i]==lhs_ptr[i-1]) produce no lanes.
REQ-026 Latency: seg_valid first high in the cycle after lhs_start acceptance (base build).
REQ-027 done high exactly in DONE state; lhs_ready low in RUN and DONE.
REQ-028 Outside RUN all seg_* outputs are 0.
REQ-029 Precondition: total <= N*N-1 (dbLgN width); larger totals are illegal input.

Reset
REQ-030 Reset low forces IDLE, k=0, captured pointers 0, lhs_ready=1, all other outputs 0, immediately and regardless of state; in-flight tile discarded, no done pulse.

Configuration
REQ-031 Macro SEG_OUT_REG_EN: when defined, all seg_* outputs come from a one-entry output register slice; first seg_valid is two cycles after acceptance; throughput remains one batch/cycle under continuous seg_ready; done follows the last registered handshake.
REQ-032 Without SEG_OUT_REG_EN, seg_* are combinational from k and captured pointers (REQ-026 latency).

Verification (N=16)
REQ-033 lhs_ptr all 16 -> one batch: split only lane 15, out_idx all 0, lane_vld all 1, carry=0, last=1, done next cycle after handshake.
REQ-034 lhs_ptr[i]=i+1 -> one batch: split all 1, out_idx[j]=j, last=1.
REQ-035 lhs_ptr all 0 -> seg_valid never high; done pulses cycle after start; lhs_ready back high next cycle.
REQ-036 lhs_ptr all 20 -> batch0 split lane 15 only, out_idx 0; batch1 lane_vld lanes 0-3, split lane 3, carry=1, last=1.
REQ-037 lhs_ptr={3,3,10,...,10}, seg_ready low 5 cycles, lhs_start pulsed in RUN -> outputs held stable, start ignored; lanes 0-2 row 0 split lane 2, lanes 3-9 row 2 split lane 9.
REQ-038 Reset asserted mid-RUN of 2-batch tile -> outputs 0 same cycle, no done, new tile then runs correctly.
